// File: rtl/packet_ejector.sv
// ---------------------------------------------------------------------------
// packet_ejector
//
// Purpose:
//   Drains flits from a router's local output port into a small circular
//   FIFO and hands them one at a time to a CPU packet receiver over a
//   four-phase request/acknowledge handshake (recieved / hand_shake).
//   Tail flits that complete a handshake are counted in pkt_cnt.
//
// Optional feature:
//   Define the macro PKT_CHECK_EN to enable a packet-framing checker on
//   accepted flits. It tracks head/tail framing, drops malformed flits and
//   counts protocol errors in a saturating err_cnt. Without the macro every
//   accepted flit is written and err_cnt is tied to zero.
//
// Parameters:
//   LL     flit width; bits [LL-1:LL-2] are the flit type
//          (00 head, 01 body, 10 tail, 11 reserved)
//   DEPTH  FIFO depth in flits (power of two, >= 2)
//   AW     FIFO pointer width, log2(DEPTH)
//
// Ports:
//   clk         single clock, rising-edge active
//   reset       asynchronous active-high reset
//   turnoff     stop request: blocks acceptance and new launches
//   in_valid    router presents in_flit
//   in_flit     flit from the router
//   in_ready    ejector can accept in_flit this cycle
//   recieved    request to the CPU receiver
//   flit        flit for the CPU receiver, stable while recieved is high
//   hand_shake  acknowledge from the CPU receiver
//   pkt_cnt     tail flits delivered (wraps at 16 bits)
//   err_cnt     framing errors seen (saturates at 255)
// ---------------------------------------------------------------------------
module packet_ejector #(
    parameter int LL    = 16,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          turnoff,
    input  logic          in_valid,
    input  logic [LL-1:0] in_flit,
    output logic          in_ready,
    output logic          recieved,
    output logic [LL-1:0] flit,
    input  logic          hand_shake,
    output logic [15:0]   pkt_cnt,
    output logic [7:0]    err_cnt
);

    localparam logic [1:0]  TYPE_TAIL  = 2'b10;
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] CNT_ONE    = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        REL  = 2'b10
    } state_t;

    // Extract the two-bit type field from a flit.
    function automatic logic [1:0] flit_type(input logic [LL-1:0] f);
        return f[LL-1:LL-2];
    endfunction

    // True when the flit closes a packet.
    function automatic logic is_tail(input logic [LL-1:0] f);
        return (flit_type(f) == TYPE_TAIL);
    endfunction

    // FIFO storage and bookkeeping
    logic [LL-1:0] mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;

    // Output side
    state_t        state_r;
    logic          recieved_r;
    logic [LL-1:0] flit_r;
    logic [15:0]   pkt_cnt_r;

    // Handshake between the two sides
    logic full_s;
    logic in_ready_s;
    logic accept_s;
    logic write_ok_s;
    logic push_s;
    logic pop_s;

    // Flow control: everything derives from registered state plus turnoff.
    // pop_s looks only at the registered count, so a flit written on this
    // edge cannot be launched on the same edge and an empty FIFO is never
    // popped.
    always_comb begin
        full_s     = (count_r == FULL_COUNT);
        in_ready_s = ~full_s & ~turnoff;
        accept_s   = in_valid & in_ready_s;
        push_s     = accept_s & write_ok_s;
        pop_s      = (state_r == IDLE) && (count_r != '0) && ~turnoff && ~hand_shake;
    end

`ifdef PKT_CHECK_EN
    localparam logic [1:0] TYPE_HEAD = 2'b00;
    localparam logic [1:0] TYPE_BODY = 2'b01;

    logic       in_pkt_r;
    logic [7:0] err_cnt_r;
    logic       frame_err_s;

    // Classify the offered flit against the current framing state.
    // A head inside a packet is still written; orphan body/tail flits and
    // reserved types are dropped.
    always_comb begin
        write_ok_s  = 1'b1;
        frame_err_s = 1'b0;
        case (flit_type(in_flit))
            TYPE_HEAD: begin
                write_ok_s  = 1'b1;
                frame_err_s = in_pkt_r;
            end
            TYPE_BODY, TYPE_TAIL: begin
                write_ok_s  = in_pkt_r;
                frame_err_s = ~in_pkt_r;
            end
            default: begin
                write_ok_s  = 1'b0;
                frame_err_s = 1'b1;
            end
        endcase
    end

    // Packet framing tracker, updated only on accepted flits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_pkt_r <= 1'b0;
        end else if (accept_s) begin
            case (flit_type(in_flit))
                TYPE_HEAD: in_pkt_r <= 1'b1;
                TYPE_TAIL: in_pkt_r <= 1'b0;
                default:   in_pkt_r <= in_pkt_r;
            endcase
        end else begin
            in_pkt_r <= in_pkt_r;
        end
    end

    // Saturating error counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_cnt_r <= 8'h00;
        end else if (accept_s && frame_err_s && (err_cnt_r != 8'hFF)) begin
            err_cnt_r <= err_cnt_r + 8'h01;
        end else begin
            err_cnt_r <= err_cnt_r;
        end
    end

    assign err_cnt = err_cnt_r;
`else
    assign write_ok_s = 1'b1;
    assign err_cnt    = 8'h00;
`endif

    // FIFO data array; contents need no reset because occupancy is cleared.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= in_flit;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at AW bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Four-phase output FSM with registered request, flit and packet count.
    // IDLE launches the FIFO head, REQ waits for the acknowledge, REL waits
    // for the acknowledge to drop. A launch therefore spans at least three
    // edges before the next one, and turnoff only gates the launch in IDLE
    // so an in-flight handshake always completes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= IDLE;
            recieved_r <= 1'b0;
            flit_r     <= '0;
            pkt_cnt_r  <= 16'h0000;
        end else begin
            case (state_r)
                IDLE: begin
                    if (pop_s) begin
                        flit_r     <= mem_r[rd_ptr_r];
                        recieved_r <= 1'b1;
                        state_r    <= REQ;
                    end
                end
                REQ: begin
                    if (hand_shake) begin
                        recieved_r <= 1'b0;
                        state_r    <= REL;
                        if (is_tail(flit_r)) begin
                            pkt_cnt_r <= pkt_cnt_r + 16'h0001;
                        end
                    end
                end
                REL: begin
                    if (!hand_shake) begin
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    recieved_r <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready = in_ready_s;
    assign recieved = recieved_r;
    assign flit     = flit_r;
    assign pkt_cnt  = pkt_cnt_r;

endmodule

// File: tb/tb_packet_ejector.sv
// ---------------------------------------------------------------------------
// tb_packet_ejector
//
// Directed bench for packet_ejector. Stimulus pushes each flit it expects
// to see delivered into a scoreboard queue; a monitor pops and compares on
// every rising edge of recieved. A responder process plays the CPU side,
// echoing recieved onto hand_shake 2 ns later while hs_en is set.
// ---------------------------------------------------------------------------
module tb_packet_ejector;

`ifdef PKT_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        turnoff = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_flit = 16'h0000;
    logic        in_ready;
    logic        recieved;
    logic [15:0] flit;
    logic        hand_shake;
    logic [15:0] pkt_cnt;
    logic [7:0]  err_cnt;

    logic        hs_en = 1'b0;
    logic [15:0] exp_q[$];
    logic [15:0] last_exp = 16'h0000;
    int          delivered = 0;
    int          tests = 0;
    int          fails = 0;

    packet_ejector #(.LL(16), .DEPTH(4), .AW(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .turnoff    (turnoff),
        .in_valid   (in_valid),
        .in_flit    (in_flit),
        .in_ready   (in_ready),
        .recieved   (recieved),
        .flit       (flit),
        .hand_shake (hand_shake),
        .pkt_cnt    (pkt_cnt),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // CPU receiver: acknowledge follows the request by 2 ns when enabled.
    initial begin
        hand_shake = 1'b0;
        forever begin
            @(recieved or hs_en);
            #2;
            hand_shake = hs_en & recieved;
        end
    end

    // Scoreboard monitor: every new request must carry the next expected flit.
    initial begin
        forever begin
            @(posedge recieved);
            #1;
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_flit: got %h, expected none", flit);
            end else begin
                last_exp = exp_q.pop_front();
                check("flit_order", flit, last_exp);
            end
            delivered++;
        end
    end

    // Flit must still be the launched value when the acknowledge arrives.
    initial begin
        forever begin
            @(posedge hand_shake);
            if (recieved) check("flit_stable", flit, last_exp);
        end
    end

    // Offer one flit (called just after a falling edge); returns after the
    // accepting rising edge, at the following falling edge.
    task automatic send(input logic [15:0] f, input bit deliver);
        bit rdy = 1'b0;
        int n = 0;
        in_valid = 1'b1;
        in_flit  = f;
        while (!rdy && n < 50) begin
            rdy = in_ready;
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        check("send_accepted", {31'd0, rdy}, 32'd1);
        if (rdy && deliver) exp_q.push_back(f);
    endtask

    // Wait until all expected flits are delivered and the handshake is idle.
    task automatic drain(input int max);
        int n = 0;
        while ((exp_q.size() != 0 || recieved || hand_shake) && n < max) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        check("drain_pending", exp_q.size(), 0);
    endtask

    initial begin
        int d0;
        bit rdy;
        int n;

        // Reset state, checked before any clock edge.
        #1 reset = 1'b1;
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_recieved", {31'd0, recieved}, 32'd0);
        check("rst_flit", flit, 32'h0);
        check("rst_pkt_cnt", pkt_cnt, 32'd0);
        check("rst_err_cnt", err_cnt, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Basic packet with an echoing receiver.
        hs_en = 1'b1;
        send(16'h0012, 1'b1);
        send(16'h4034, 1'b1);
        send(16'h8056, 1'b1);
        in_valid = 1'b0;
        drain(100);
        check("s1_pkt_cnt", pkt_cnt, 32'd1);
        check("s1_err_cnt", err_cnt, 32'd0);

        // Backpressure: one flit held in REQ, then fill the FIFO.
        hs_en = 1'b0;
        send(16'h0100, 1'b1);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("s2_held_req", {31'd0, recieved}, 32'd1);
        send(16'h4101, 1'b1);
        send(16'h4102, 1'b1);
        send(16'h4103, 1'b1);
        send(16'h4104, 1'b1);
        in_valid = 1'b1;
        in_flit  = 16'h8105;
        for (int i = 0; i < 3; i++) begin
            check("s2_ready_full", {31'd0, in_ready}, 32'd0);
            @(posedge clk);
            @(negedge clk);
        end
        hs_en = 1'b1;
        rdy = 1'b0;
        n = 0;
        while (!rdy && n < 20) begin
            @(negedge clk);
            rdy = in_ready;
            n++;
        end
        check("s2_ready_back", {31'd0, rdy}, 32'd1);
        check("s2_pop_before_accept", flit, 32'h4101);
        check("s2_req_at_reopen", {31'd0, recieved}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        exp_q.push_back(16'h8105);
        in_valid = 1'b0;
        drain(200);
        check("s2_pkt_cnt", pkt_cnt, 32'd2);

        // Framing: orphan body, double head, tail, reserved type.
        send(16'h4001, !CHK);
        in_valid = 1'b0;
        drain(100);
        check("s3_err_orphan", err_cnt, CHK ? 32'd1 : 32'd0);
        send(16'h0001, 1'b1);
        send(16'h0002, 1'b1);
        in_valid = 1'b0;
        drain(100);
        check("s3_err_dbl_head", err_cnt, CHK ? 32'd2 : 32'd0);
        send(16'h8003, 1'b1);
        send(16'hC000, !CHK);
        in_valid = 1'b0;
        drain(100);
        check("s3_err_reserved", err_cnt, CHK ? 32'd3 : 32'd0);
        check("s3_pkt_cnt", pkt_cnt, 32'd3);

        // Turnoff during REQ: handshake completes, nothing more launches.
        hs_en = 1'b0;
        send(16'h0200, 1'b1);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("s4_req", {31'd0, recieved}, 32'd1);
        send(16'h4201, 1'b1);
        in_valid = 1'b0;
        d0 = delivered;
        turnoff = 1'b1;
        #1;
        check("s4_ready_off", {31'd0, in_ready}, 32'd0);
        hs_en = 1'b1;
        repeat (10) @(negedge clk);
        check("s4_no_launch", {31'd0, recieved}, 32'd0);
        check("s4_hs_done", {31'd0, hand_shake}, 32'd0);
        check("s4_delivered", delivered, d0);
        check("s4_retained", exp_q.size(), 32'd1);
        check("s4_ready_still_off", {31'd0, in_ready}, 32'd0);

        // Reset mid-handshake with three flits queued.
        hs_en = 1'b0;
        turnoff = 1'b0;
        send(16'h4202, 1'b1);
        send(16'h4203, 1'b1);
        send(16'h8204, 1'b1);
        in_valid = 1'b0;
        check("s5_req_before_rst", {31'd0, recieved}, 32'd1);
        #2 reset = 1'b1;
        #1;
        check("s5_rst_recieved", {31'd0, recieved}, 32'd0);
        check("s5_rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("s5_rst_pkt_cnt", pkt_cnt, 32'd0);
        check("s5_rst_flit", flit, 32'h0);
        check("s5_rst_err_cnt", err_cnt, 32'd0);
        exp_q.delete();
        d0 = delivered;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        hs_en = 1'b1;
        repeat (12) @(negedge clk);
        check("s5_nothing_after", delivered, d0);
        check("s5_idle_after", {31'd0, recieved}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
